// File: rtl/dlx_pkg.sv
// Shared types and encodings for the DLX decode stage.
package dlx_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 32;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [3:0] {
        ALU_PASS = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_EQZ  = 4'd8,
        ALU_NEZ  = 4'd9,
        ALU_SEQ  = 4'd10,
        ALU_SLE  = 4'd11,
        ALU_SLT  = 4'd12,
        ALU_SNE  = 4'd13,
        ALU_SRA  = 4'd14,
        ALU_LINK = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JREG   = 2'b11
    } pc_sel_e;

    // Primary opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQZ  = 6'h04;
    localparam logic [OP_W-1:0] OP_BNEZ  = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SUBI  = 6'h0a;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0e;
    localparam logic [OP_W-1:0] OP_LHI   = 6'h0f;
    localparam logic [OP_W-1:0] OP_JR    = 6'h12;
    localparam logic [OP_W-1:0] OP_JALR  = 6'h13;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'h14;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'h16;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'h17;
    localparam logic [OP_W-1:0] OP_SEQI  = 6'h18;
    localparam logic [OP_W-1:0] OP_SNEI  = 6'h19;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h1a;
    localparam logic [OP_W-1:0] OP_SLEI  = 6'h1c;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h04;
    localparam logic [5:0] FN_SRL = 6'h06;
    localparam logic [5:0] FN_SRA = 6'h07;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SEQ = 6'h28;
    localparam logic [5:0] FN_SNE = 6'h29;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_SLE = 6'h2c;

    // Decoded payload; register indices and immediate are at native
    // instruction width and widened by the stage to its parameters.
    typedef struct packed {
        alu_op_e           alu_op;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [IMM_W-1:0]  imm;
        logic              use_imm;
        pc_sel_e           pc_sel;
        logic              load;
        logic              store;
        logic              illegal;
    } decoded_t;

    // Opcodes whose 16-bit immediate is sign-extended
    function automatic logic imm_is_signed(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI, OP_SUBI, OP_SEQI, OP_SNEI, OP_SLTI, OP_SLEI,
            OP_LW, OP_SW, OP_BEQZ, OP_BNEZ: imm_is_signed = 1'b1;
            default:                         imm_is_signed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dlx_decode_comb.sv
// Combinational DLX instruction decoder: instruction word to decoded fields.
module dlx_decode_comb
    import dlx_pkg::*;
#(
    parameter int unsigned LINK_REG = 31
) (
    input  logic [INSTR_W-1:0] instr,
    output decoded_t           dec,
    output logic               use_rs1,
    output logic               use_rs2
);

    logic [OP_W-1:0]  opcode;
    logic [5:0]       funct;
    logic [REG_W-1:0] f_a;
    logic [REG_W-1:0] f_b;
    logic [REG_W-1:0] f_c;
    logic [IMM_W-1:0] imm_i;
    logic [IMM_W-1:0] imm_j;

    assign opcode = instr[31:26];
    assign f_a    = instr[25:21];
    assign f_b    = instr[20:16];
    assign f_c    = instr[15:11];
    assign funct  = instr[5:0];
    assign imm_i  = imm_is_signed(opcode) ? {{16{instr[15]}}, instr[15:0]}
                                          : {16'b0, instr[15:0]};
    assign imm_j  = {{6{instr[25]}}, instr[25:0]};

    // Field extraction and control decode; anything unrecognised is a nop flagged illegal
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_SLL:  dec.alu_op = ALU_SLL;
                    FN_SRL:  dec.alu_op = ALU_SRL;
                    FN_SRA:  dec.alu_op = ALU_SRA;
                    FN_SEQ:  dec.alu_op = ALU_SEQ;
                    FN_SNE:  dec.alu_op = ALU_SNE;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLE:  dec.alu_op = ALU_SLE;
                    default: dec.illegal = 1'b1;
                endcase
                if (!dec.illegal) begin
                    dec.rs1 = f_a;
                    dec.rs2 = f_b;
                    dec.rd  = f_c;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_LHI,
            OP_SLLI, OP_SRLI, OP_SRAI, OP_SEQI, OP_SNEI, OP_SLTI, OP_SLEI: begin
                case (opcode)
                    OP_ADDI: dec.alu_op = ALU_ADD;
                    OP_SUBI: dec.alu_op = ALU_SUB;
                    OP_ANDI: dec.alu_op = ALU_AND;
                    OP_ORI:  dec.alu_op = ALU_OR;
                    OP_XORI: dec.alu_op = ALU_XOR;
                    OP_SLLI: dec.alu_op = ALU_SLL;
                    OP_SRLI: dec.alu_op = ALU_SRL;
                    OP_SRAI: dec.alu_op = ALU_SRA;
                    OP_SEQI: dec.alu_op = ALU_SEQ;
                    OP_SNEI: dec.alu_op = ALU_SNE;
                    OP_SLTI: dec.alu_op = ALU_SLT;
                    OP_SLEI: dec.alu_op = ALU_SLE;
                    default: dec.alu_op = ALU_PASS;
                endcase
                dec.rs1     = f_a;
                dec.rd      = f_b;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                use_rs1     = 1'b1;
            end
            OP_LW: begin
                dec.alu_op  = ALU_ADD;
                dec.rs1     = f_a;
                dec.rd      = f_b;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                dec.load    = 1'b1;
                use_rs1     = 1'b1;
            end
            OP_SW: begin
                dec.alu_op  = ALU_ADD;
                dec.rs1     = f_a;
                dec.rs2     = f_b;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                dec.store   = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OP_BEQZ, OP_BNEZ: begin
                dec.alu_op  = (opcode == OP_BEQZ) ? ALU_EQZ : ALU_NEZ;
                dec.rs1     = f_a;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                dec.pc_sel  = PC_BRANCH;
                use_rs1     = 1'b1;
            end
            OP_JR, OP_JALR: begin
                dec.alu_op  = (opcode == OP_JALR) ? ALU_LINK : ALU_PASS;
                dec.rd      = (opcode == OP_JALR) ? REG_W'(LINK_REG) : '0;
                dec.rs1     = f_a;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                dec.pc_sel  = PC_JREG;
                use_rs1     = 1'b1;
            end
            OP_J, OP_JAL: begin
                dec.alu_op  = (opcode == OP_JAL) ? ALU_LINK : ALU_PASS;
                dec.rd      = (opcode == OP_JAL) ? REG_W'(LINK_REG) : '0;
                dec.imm     = imm_j;
                dec.pc_sel  = PC_JUMP;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dlx_decode_stage.sv
// DLX decode pipeline stage: handshaked output register, load-use interlock,
// flush and saturating bubble counter around the combinational decoder.
module dlx_decode_stage
    import dlx_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RAW         = 5,
    parameter int unsigned LINK_REG    = 31,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_alu_op,
    output logic [RAW-1:0]         out_rs1,
    output logic [RAW-1:0]         out_rs2,
    output logic [RAW-1:0]         out_rd,
    output logic [XLEN-1:0]        out_imm,
    output logic                   out_use_imm,
    output logic [1:0]             out_pc_sel,
    output logic                   out_load,
    output logic                   out_store,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    decoded_t in_dec;
    decoded_t held;
    logic     in_use_rs1;
    logic     in_use_rs2;
    logic     hazard;
    logic     in_fire;
    logic     out_fire;

    dlx_decode_comb #(
        .LINK_REG (LINK_REG)
    ) u_decode (
        .instr   (in_instr),
        .dec     (in_dec),
        .use_rs1 (in_use_rs1),
        .use_rs2 (in_use_rs2)
    );

    // Load in the output register whose result the incoming instruction reads
    assign hazard = out_valid && held.load && (held.rd != '0) &&
                    ((in_use_rs1 && (in_dec.rs1 == held.rd)) ||
                     (in_use_rs2 && (in_dec.rs2 == held.rd)));

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Output register: flush wins, then accept, then drain (counting interlock bubbles)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            held        <= '0;
            stall_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            held      <= in_dec;
        end else if (out_fire) begin
            out_valid <= 1'b0;
            if (hazard && (stall_count != STALL_MAX)) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end
        end
    end

    // Widen held fields to the stage parameters; immediates are sign-extended
    // from bit 31, which is already zero for zero-extended 16-bit forms.
    assign out_alu_op  = held.alu_op;
    assign out_rs1     = RAW'(held.rs1);
    assign out_rs2     = RAW'(held.rs2);
    assign out_rd      = RAW'(held.rd);
    assign out_imm     = XLEN'($signed(held.imm));
    assign out_use_imm = held.use_imm;
    assign out_pc_sel  = held.pc_sel;
    assign out_load    = held.load;
    assign out_store   = held.store;
    assign out_illegal = held.illegal;

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Scoreboard bench for dlx_decode_stage: directed instructions with hand-decoded expectations.
module tb_dlx_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic [1:0]  out_pc_sel;
    logic        out_load, out_store, out_illegal;
    logic [15:0] stall_count;

    typedef struct {
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        chk_imm;
        logic        use_imm;
        logic        chk_use;
        logic [1:0]  pc;
        logic        load, store, illegal;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dlx_decode_stage #(
        .XLEN(32), .RAW(5), .LINK_REG(31), .STALL_CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_use_imm(out_use_imm), .out_pc_sel(out_pc_sel),
        .out_load(out_load), .out_store(out_store), .out_illegal(out_illegal),
        .stall_count(stall_count)
    );

    function automatic exp_t mk(input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm, input logic chk_imm,
                                input logic use_imm, input logic chk_use, input logic [1:0] pc,
                                input logic ld, input logic st, input logic ill);
        exp_t e;
        e.alu = alu; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.imm = imm; e.chk_imm = chk_imm; e.use_imm = use_imm; e.chk_use = chk_use;
        e.pc = pc; e.load = ld; e.store = st; e.illegal = ill;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Present one instruction until accepted; returns cycles spent waiting
    task automatic send(input logic [31:0] instr, input exp_t e, output int waits);
        bit done = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_instr = instr;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
                if (waits >= 20) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: instr %08h never accepted", instr);
                    done = 1'b1;
                end
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_instr = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer is matched against the oldest expectation
    initial begin
        logic [63:0] act, req;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(out_alu_op), 64'hDEAD);
                end else begin
                    e   = exp_q.pop_front();
                    act = {7'd0, out_alu_op, out_rs1, out_rs2, out_rd,
                           e.chk_imm ? out_imm : 32'd0, e.chk_use ? out_use_imm : 1'b0,
                           out_pc_sel, out_load, out_store, out_illegal};
                    req = {7'd0, e.alu, e.rs1, e.rs2, e.rd,
                           e.chk_imm ? e.imm : 32'd0, e.chk_use ? e.use_imm : 1'b0,
                           e.pc, e.load, e.store, e.illegal};
                    check("decode_out", act, req);
                end
            end
        end
    end

    initial begin
        int w;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_state", {out_valid, in_ready, stall_count, out_alu_op, out_rd, out_imm},
              {1'b0, 1'b1, 16'd0, 4'd0, 5'd0, 32'd0});
        @(posedge clk); #1;

        // add r3,r1,r2
        send(32'h00221820, mk(4'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);

        // lw r5,4(r1) then add r6,r5,r2: one bubble
        send(32'h8C250004, mk(4'd1, 5'd1, 5'd0, 5'd5, 32'd4, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0), w);
        send(32'h00A23020, mk(4'd1, 5'd5, 5'd2, 5'd6, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        check("load_use_wait", 64'(w), 64'd1);
        check("stall_after_hazard", 64'(stall_count), 64'd1);

        // lw r0,4(r1) then add r6,r0,r2: no interlock
        send(32'h8C200004, mk(4'd1, 5'd1, 5'd0, 5'd0, 32'd4, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0), w);
        send(32'h00023020, mk(4'd1, 5'd0, 5'd2, 5'd6, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        check("r0_load_wait", 64'(w), 64'd0);
        check("stall_r0", 64'(stall_count), 64'd1);

        // addi r4,r1,-1 / andi r4,r1,0xffff / sw r5,8(r1) / beqz r1,-4 / jalr r2 / slt r11,r1,r2
        send(32'h2024FFFF, mk(4'd1, 5'd1, 5'd0, 5'd4, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        send(32'h3024FFFF, mk(4'd3, 5'd1, 5'd0, 5'd4, 32'h0000FFFF, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        send(32'hAC250008, mk(4'd1, 5'd1, 5'd5, 5'd0, 32'd8, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0), w);
        send(32'h1020FFFC, mk(4'd8, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0), w);
        send(32'h4C400000, mk(4'd15, 5'd2, 5'd0, 5'd31, 32'd0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0), w);
        send(32'h0022582A, mk(4'd12, 5'd1, 5'd2, 5'd11, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        // illegal opcode 0x3f, illegal funct 0x3f, jal -8
        send(32'hFC221820, mk(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1), w);
        send(32'h0022183F, mk(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1), w);
        send(32'h0FFFFFF8, mk(4'd15, 5'd0, 5'd0, 5'd31, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0), w);

        // Backpressure: or r7,r1,r2 held for 3 cycles, then xor r8,r1,r2
        idle(2);
        out_ready = 1'b0;
        send(32'h00223825, mk(4'd4, 5'd1, 5'd2, 5'd7, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_stable", {out_valid, in_ready, out_alu_op, out_rs1, out_rs2, out_rd},
                  {1'b1, 1'b0, 4'd4, 5'd1, 5'd2, 5'd7});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h00224026, mk(4'd5, 5'd1, 5'd2, 5'd8, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        check("release_wait", 64'(w), 64'd0);

        // Flush: sub r9 held, flush with and r10 presented; and must be re-sent
        idle(2);
        out_ready = 1'b0;
        send(32'h00224822, mk(4'd2, 5'd1, 5'd2, 5'd9, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00225024;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_kills", {out_valid, stall_count}, {1'b0, 16'd1});
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00225024, mk(4'd3, 5'd1, 5'd2, 5'd10, 32'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), w);
        check("represent_wait", 64'(w), 64'd0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dlx_decode_stage.md
# dlx_decode_stage

Parametrised DLX instruction-decode pipeline stage that sits between instruction fetch and execute. It extends the single-cycle decoder with:
- valid/ready handshakes on both sides;
- a one-entry decoded-instruction output register;
- load-use hazard interlock (one bubble);
- synchronous flush from branch resolution;
- illegal-instruction flagging;
- a saturating stall counter.

## Interface
Parameters:
- XLEN, 32, data/immediate width (≥32)
- RAW, 5, register address width
- LINK_REG, 31, destination index for jal/jalr
- STALL_CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  32  instruction word
- flush  in  1  kill stage contents (branch taken in execute)
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts decoded instruction
- out_alu_op  out  4  alu_op_e code
- out_rs1, out_rs2, out_rd  out  RAW  register indices (rd=0 means no write)
- out_imm  out  XLEN  extended immediate
- out_use_imm  out  1  ALU operand B is out_imm
- out_pc_sel  out  2  00 sequential, 01 cond branch pc-rel, 10 jump pc-rel, 11 jump register
- out_load, out_store  out  1  memory read / write
- out_illegal  out  1  undecodable instruction, decoded as nop
- stall_count  out  STALL_CNT_W  hazard bubbles inserted, saturating

## Operation
ALU codes:
- 0 pass
- 1 add
- 2 sub
- 3 and
- 4 or
- 5 xor
- 6 sll
- 7 srl
- 8 eqz
- 9 nez
- 10 seq
- 11 sle
- 12 slt/sgt as existing ALU
- 13 sne
- 14 sra
- 15 link

R-type (opcode 0x00):
- funct to alu_op: 20→1, 22→2, 24→3, 25→4, 26→5, 04→6, 06→7, 07→14, 28→10, 29→13, 2a→12, 2c→11.
- rs1=[25:21], rs2=[20:16], rd=[15:11], use_imm=0.

I-type: rs1=[25:21], rd=[20:16], use_imm=1.
- Opcode to alu_op: 08→1, 0a→2, 0c→3, 0d→4, 0e→5, 14→6, 16→7, 17→14, 18→10, 19→13, 1a→12, 1c→11, 0f(lhi)→0.
- Immediate: sign-extended for 08, 0a, 18, 19, 1a, 1c, 23, 2b, 04, 05; zero-extended otherwise.
- 23 lw: alu 1, load=1.
- 2b sw: alu 1, store=1, rs2=[20:16], rd=0.
- 04 beqz / 05 bnez: alu 8/9, pc_sel 01, rd=0.
- 12 jr: pc_sel 11, alu 0, rd=0.
- 13 jalr: pc_sel 11, alu 15, rd=LINK_REG.

J-type:
- 02 j: pc_sel 10, rd=0, imm = sign-extended [25:0].
- 03 jal: same as j, plus alu 15, rd=LINK_REG.

Illegal instructions:
- Any other opcode or funct sets illegal=1.
- All enables 0, rd=0, alu 0, pc_sel 00.

Register source use:
- R-type and store: both rs1 and rs2.
- I-type ALU, load, branch, jr, jalr: rs1 only.
- j, jal, illegal: none.
- Unused rs fields are output as 0.

Hazard: `hazard = out_valid & out_load & out_rd≠0 & (out_rd matches a used rs of in_instr)`.

Handshake and control:
- `in_ready = !flush & !hazard & (!out_valid | out_ready)`.
- Input fire: in_valid & in_ready. Output register loads the decoded fields and out_valid=1.
- Output fire without input fire: out_valid←0. When hazard is set, this cycle is the bubble and stall_count increments (saturating at all-ones).
- Flush, highest priority: out_valid←0, no input accepted, stall_count unchanged.
- out_* fields are held stable while out_valid & !out_ready.

## Timing
- Latency 1 cycle from input fire to out_valid.
- Full throughput when there are no hazards.
- Load-use dependence costs exactly one bubble cycle.
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, stall_count=0.
  - All out_* fields 0.
  - in_ready follows its equation, so it reads 1 after reset.
- Reset mid-stall discards the held instruction.
- Simultaneous flush and in_valid: the instruction is not accepted, and fetch must re-present it.
- rd=0 loads never cause a hazard.

## Structure
- Package dlx_pkg holds:
  - alu_op_e;
  - pc_sel_e;
  - opcode/funct localparams;
  - a decoded_t struct of all out_* fields except valid.
- Sub-module dlx_decode_comb: purely combinational in_instr→decoded_t plus rs-use bits.
- dlx_decode_stage holds the register, handshake, hazard logic and counter.

## Test plan
- Reset, then `add r3,r1,r2` (0x00221820) with out_ready=1 → next cycle out_valid=1, alu 1, rs1=1, rs2=2, rd=3.
- `lw r5,4(r1)` then `add r6,r5,r2` back-to-back → one bubble cycle (out_valid=0), stall_count=1, add appears one cycle later.
- `lw r0,...` then a consumer of r0 → no bubble, stall_count unchanged.
- out_ready=0 for 3 cycles with valid output → fields stable, in_ready=0; release → next instruction accepted.
- flush asserted while out_valid=1 and in_valid=1 → out_valid=0 next cycle, input not consumed.
- Opcode 0x3f → out_illegal=1, rd=0, load=store=0; `jal -8` → imm=0xFFFFFFF8, rd=31, pc_sel 10, alu 15.
